// File: rtl/grid_lcd_renderer_if.sv
// Control and SPI-LCD signal bundle for grid_lcd_renderer.
// The renderer uses the slave view; whoever requests frames and receives the LCD lines uses master.
interface grid_lcd_renderer_if;
  logic         start;
  logic [199:0] grid_state;
  logic         busy;
  logic         done;
  logic         lcd_sda;
  logic         lcd_scl;
  logic         lcd_cs;
  logic         lcd_rs;

  modport master (
    output start, grid_state,
    input  busy, done, lcd_sda, lcd_scl, lcd_cs, lcd_rs
  );

  modport slave (
    input  start, grid_state,
    output busy, done, lcd_sda, lcd_scl, lcd_cs, lcd_rs
  );
endinterface

// File: rtl/grid_lcd_renderer.sv
// Renders the 10x20 tetris playfield snapshot to an SPI LCD: CASET/RASET/RAMWR
// followed by an RGB565 stream, each cell drawn as a CELL_PX x CELL_PX block.
module grid_lcd_renderer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CELL_PX  = 6,
  parameter int unsigned X_OFF    = 0,
  parameter int unsigned Y_OFF    = 0,
  parameter logic [15:0] FG_COLOR = 16'hFFE0,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input logic                clk,
  input logic                reset,
  grid_lcd_renderer_if.slave bus
);

  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW       = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);
  localparam logic [15:0] X_FIRST  = 16'(X_OFF);
  localparam logic [15:0] X_LAST   = 16'(X_OFF + 10 * CELL_PX - 1);
  localparam logic [15:0] Y_FIRST  = 16'(Y_OFF);
  localparam logic [15:0] Y_LAST   = 16'(Y_OFF + 20 * CELL_PX - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_CASET, PAR_CASET, CMD_RASET, PAR_RASET, CMD_RAMWR, PIXELS, FINISH
  } state_t;

  state_t state, state_nx;

  logic [1:0]    idx, idx_nx;
  logic [SW-1:0] sub_x, sub_x_nx;
  logic [SW-1:0] sub_y, sub_y_nx;
  logic [3:0]    col, col_nx;
  logic [7:0]    row_base, row_base_nx;
  logic          pix_lo, pix_lo_nx;
  logic [199:0]  snap;

  logic [DW-1:0] div_cnt;
  logic          phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rs_i;

  logic          active, tick, byte_end, accept, load;
  logic [7:0]    cell_nx;
  logic [15:0]   color_nx;
  logic [7:0]    byte_nx;
  logic          rs_nx;

  always_comb begin
    active   = (state != IDLE) && (state != FINISH);
    tick     = (div_cnt == DIV_LAST);
    byte_end = active && phase && tick && (bit_cnt == 3'd7);
    accept   = (state == IDLE) && bus.start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      col      <= '0;
      row_base <= '0;
      pix_lo   <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      sub_x    <= sub_x_nx;
      sub_y    <= sub_y_nx;
      col      <= col_nx;
      row_base <= row_base_nx;
      pix_lo   <= pix_lo_nx;
    end
  end

  // Pixel walk: sub-pixel x, then column, then sub-pixel y, then row (row_base = row*10).
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    sub_x_nx    = sub_x;
    sub_y_nx    = sub_y;
    col_nx      = col;
    row_base_nx = row_base;
    pix_lo_nx   = pix_lo;
    case (state)
      IDLE:      if (bus.start) state_nx = CMD_CASET;
      CMD_CASET: if (byte_end) begin
                   state_nx = PAR_CASET;
                   idx_nx   = '0;
                 end
      PAR_CASET: if (byte_end) begin
                   if (idx == 2'd3) state_nx = CMD_RASET;
                   else             idx_nx   = idx + 2'd1;
                 end
      CMD_RASET: if (byte_end) begin
                   state_nx = PAR_RASET;
                   idx_nx   = '0;
                 end
      PAR_RASET: if (byte_end) begin
                   if (idx == 2'd3) state_nx = CMD_RAMWR;
                   else             idx_nx   = idx + 2'd1;
                 end
      CMD_RAMWR: if (byte_end) begin
                   state_nx    = PIXELS;
                   sub_x_nx    = '0;
                   sub_y_nx    = '0;
                   col_nx      = '0;
                   row_base_nx = '0;
                   pix_lo_nx   = 1'b0;
                 end
      PIXELS:    if (byte_end) begin
                   if (!pix_lo) begin
                     pix_lo_nx = 1'b1;
                   end else begin
                     pix_lo_nx = 1'b0;
                     if (sub_x != SUB_LAST) begin
                       sub_x_nx = sub_x + SW'(1);
                     end else begin
                       sub_x_nx = '0;
                       if (col != 4'd9) begin
                         col_nx = col + 4'd1;
                       end else begin
                         col_nx = '0;
                         if (sub_y != SUB_LAST) begin
                           sub_y_nx = sub_y + SW'(1);
                         end else begin
                           sub_y_nx = '0;
                           if (row_base == 8'd190) state_nx    = FINISH;
                           else                    row_base_nx = row_base + 8'd10;
                         end
                       end
                     end
                   end
                 end
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // The byte loaded at a byte boundary is chosen from the position being entered.
  always_comb begin
    load     = accept || (byte_end && (state_nx != FINISH));
    cell_nx  = row_base_nx + {4'd0, col_nx};
    color_nx = snap[cell_nx] ? FG_COLOR : BG_COLOR;
    byte_nx  = '0;
    rs_nx    = 1'b1;
    case (state_nx)
      CMD_CASET: begin byte_nx = 8'h2A; rs_nx = 1'b0; end
      CMD_RASET: begin byte_nx = 8'h2B; rs_nx = 1'b0; end
      CMD_RAMWR: begin byte_nx = 8'h2C; rs_nx = 1'b0; end
      PAR_CASET: case (idx_nx)
                   2'd0:    byte_nx = X_FIRST[15:8];
                   2'd1:    byte_nx = X_FIRST[7:0];
                   2'd2:    byte_nx = X_LAST[15:8];
                   default: byte_nx = X_LAST[7:0];
                 endcase
      PAR_RASET: case (idx_nx)
                   2'd0:    byte_nx = Y_FIRST[15:8];
                   2'd1:    byte_nx = Y_FIRST[7:0];
                   2'd2:    byte_nx = Y_LAST[15:8];
                   default: byte_nx = Y_LAST[7:0];
                 endcase
      PIXELS:    byte_nx = pix_lo_nx ? color_nx[7:0] : color_nx[15:8];
      default:   rs_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap <= '0;
    end else if (accept) begin
      snap <= bus.grid_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      rs_i    <= 1'b0;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= byte_nx;
      rs_i    <= rs_nx;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        phase   <= ~phase;
        if (phase) begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= {shreg[6:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // The internal serialiser starts on the accepting edge; the pins lag it by one
  // register stage, which places cs fall and done exactly one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.lcd_cs  <= 1'b1;
      bus.lcd_scl <= 1'b0;
      bus.lcd_sda <= 1'b0;
      bus.lcd_rs  <= 1'b0;
    end else begin
      if (accept)                bus.busy <= 1'b1;
      else if (state == FINISH)  bus.busy <= 1'b0;
      bus.done    <= (state == FINISH);
      bus.lcd_cs  <= ~active;
      bus.lcd_scl <= active & phase;
      bus.lcd_sda <= active & shreg[7];
      bus.lcd_rs  <= active & rs_i;
    end
  end

endmodule

// File: tb/tb_grid_lcd_renderer.sv
// Self-checking bench for grid_lcd_renderer: three parameterisations, byte streams
// captured from the SPI pins and compared with a pixel-level reference model.
module tb_grid_lcd_renderer;

  logic clk;
  logic rst_a, rst_b, rst_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  grid_lcd_renderer_if ifa ();
  grid_lcd_renderer_if ifb ();
  grid_lcd_renderer_if ifc ();

  grid_lcd_renderer #(.CLK_DIV(1), .CELL_PX(1)) u_a (.clk(clk), .reset(rst_a), .bus(ifa));
  grid_lcd_renderer #(.CLK_DIV(1), .CELL_PX(2), .FG_COLOR(16'hFFE0), .BG_COLOR(16'h0000))
    u_b (.clk(clk), .reset(rst_b), .bus(ifb));
  grid_lcd_renderer #(.CLK_DIV(4), .CELL_PX(1), .X_OFF(300), .Y_OFF(5),
                      .FG_COLOR(16'h1234), .BG_COLOR(16'hABCD))
    u_c (.clk(clk), .reset(rst_c), .bus(ifc));

  logic [2:0] scl_w, sda_w, cs_w, rs_w, busy_w, done_w;
  assign scl_w  = {ifc.lcd_scl, ifb.lcd_scl, ifa.lcd_scl};
  assign sda_w  = {ifc.lcd_sda, ifb.lcd_sda, ifa.lcd_sda};
  assign cs_w   = {ifc.lcd_cs,  ifb.lcd_cs,  ifa.lcd_cs};
  assign rs_w   = {ifc.lcd_rs,  ifb.lcd_rs,  ifa.lcd_rs};
  assign busy_w = {ifc.busy,    ifb.busy,    ifa.busy};
  assign done_w = {ifc.done,    ifb.done,    ifa.done};

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int cdiv_of(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  function automatic logic [5:0] out_vec(input int k);
    return {busy_w[k], done_w[k], cs_w[k], scl_w[k], sda_w[k], rs_w[k]};
  endfunction

  // Pin monitor: captures {rs, byte} on each scl rise and counts timing violations.
  logic [8:0] cap [3][0:2047];
  int   ncap[3], bitn[3], done_cnt[3], viol[3], run[3];
  logic [7:0] acc[3];
  logic accrs[3], pscl[3], psda[3], prs[3], pcs[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      ncap[k] = 0; bitn[k] = 0; done_cnt[k] = 0; viol[k] = 0; run[k] = 0;
      acc[k] = '0; accrs[k] = 1'b0; pscl[k] = 1'b0; psda[k] = 1'b0; prs[k] = 1'b0; pcs[k] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) done_cnt[k]++;
        if (cs_w[k] && scl_w[k]) viol[k]++;
        if (!cs_w[k] && pcs[k]) begin
          ncap[k] = 0; bitn[k] = 0; run[k] = 0;
        end
        if (!cs_w[k] && !pcs[k]) begin
          if ((sda_w[k] !== psda[k] || rs_w[k] !== prs[k]) && !(pscl[k] && !scl_w[k])) viol[k]++;
          if (scl_w[k] !== pscl[k]) begin
            if (run[k] != cdiv_of(k)) viol[k]++;
            run[k] = 0;
          end
          if (!pscl[k] && scl_w[k]) begin
            acc[k] = {acc[k][6:0], sda_w[k]};
            if (bitn[k] == 0) accrs[k] = rs_w[k];
            bitn[k]++;
            if (bitn[k] == 8) begin
              if (ncap[k] < 2048) cap[k][ncap[k]] = {accrs[k], acc[k]};
              ncap[k]++;
              bitn[k] = 0;
            end
          end
        end
        if (!cs_w[k]) run[k]++;
        pscl[k] = scl_w[k]; psda[k] = sda_w[k]; prs[k] = rs_w[k]; pcs[k] = cs_w[k];
      end
    end
  end

  // Reference: the frame as a list of {rs, byte} derived from geometry alone.
  logic [8:0] exp_q[$];

  task automatic build_exp(input int cp, input int xoff, input int yoff,
                           input logic [15:0] fg, input logic [15:0] bg, input logic [199:0] g);
    int w, h, xe, ye;
    logic [15:0] c;
    w = 10 * cp; h = 20 * cp; xe = xoff + w - 1; ye = yoff + h - 1;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'(xoff / 256)}); exp_q.push_back({1'b1, 8'(xoff % 256)});
    exp_q.push_back({1'b1, 8'(xe / 256)});   exp_q.push_back({1'b1, 8'(xe % 256)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'(yoff / 256)}); exp_q.push_back({1'b1, 8'(yoff % 256)});
    exp_q.push_back({1'b1, 8'(ye / 256)});   exp_q.push_back({1'b1, 8'(ye % 256)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int py = 0; py < h; py++) begin
      for (int px = 0; px < w; px++) begin
        c = g[(py / cp) * 10 + px / cp] ? fg : bg;
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    end
  endtask

  task automatic check_stream(input int k, input int cp, input int xoff, input int yoff,
                              input logic [15:0] fg, input logic [15:0] bg,
                              input logic [199:0] g, input string tag);
    int n, idx;
    build_exp(cp, xoff, yoff, fg, bg, g);
    chk({tag, "_len"}, ncap[k], exp_q.size());
    n = (ncap[k] < exp_q.size()) ? ncap[k] : exp_q.size();
    if (n > 2048) n = 2048;
    idx = (n > 0) ? n - 1 : 0;
    for (int i = 0; i < n; i++) begin
      if (cap[k][i] !== exp_q[i]) begin
        idx = i;
        break;
      end
    end
    chk($sformatf("%s_byte%0d", tag, idx), cap[k][idx], exp_q[idx]);
  endtask

  task automatic wait_done(input int k, input int budget, input int t_start,
                           input int want, input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_w[k]) begin
        lat = cyc - t_start;
        break;
      end
    end
    chk(tag, lat, want);
  endtask

  function automatic logic [199:0] rand_grid();
    logic [199:0] g;
    for (int i = 0; i < 200; i++) g[i] = 1'($urandom_range(0, 1));
    return g;
  endfunction

  initial begin
    logic [199:0] ga, gb, gc;
    int t0, base, changes;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    ifa.grid_state = '0; ifb.grid_state = '0; ifc.grid_state = '0;

    repeat (3) @(negedge clk);
    chk("reset_a", out_vec(0), 6'b001000);
    chk("reset_b", out_vec(1), 6'b001000);
    chk("reset_c", out_vec(2), 6'b001000);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    changes = 0;
    repeat (1000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (out_vec(k) !== 6'b001000) changes++;
    end
    chk("idle_static", changes, 0);

    // Frame 1: empty grid on A, corner cells on B, random grid with offsets on C.
    ga = '0;
    gb = '0; gb[0] = 1'b1; gb[199] = 1'b1;
    gc = rand_grid();
    ifa.grid_state = ga; ifb.grid_state = gb; ifc.grid_state = gc;
    base = done_cnt[0];
    @(negedge clk);
    ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    t0 = cyc;
    chk("a_busy_rise", busy_w[0], 1'b1);
    chk("a_cs_still_high", cs_w[0], 1'b1);
    @(negedge clk);
    chk("a_cs_fall", cs_w[0], 1'b0);
    wait_done(0, 30000, t0, 1 + 411 * 16, "a_empty_latency");
    check_stream(0, 1, 0, 0, 16'hFFE0, 16'h0000, ga, "a_empty");
    wait_done(1, 30000, t0, 1 + 1611 * 16, "b_corner_latency");
    check_stream(1, 2, 0, 0, 16'hFFE0, 16'h0000, gb, "b_corner");
    chk("b_row0_first_cell", {cap[1][11][7:0], cap[1][12][7:0], cap[1][13][7:0], cap[1][14][7:0]},
        32'hFFE0FFE0);
    chk("b_row0_px2", {cap[1][15][7:0], cap[1][16][7:0]}, 16'h0000);
    chk("b_row39_last_cell", {cap[1][1607][7:0], cap[1][1608][7:0], cap[1][1609][7:0], cap[1][1610][7:0]},
        32'hFFE0FFE0);
    wait_done(2, 30000, t0, 1 + 411 * 64, "c_offset_latency");
    check_stream(2, 1, 300, 5, 16'h1234, 16'hABCD, gc, "c_offset");
    chk("a_frame1_one_done", done_cnt[0] - base, 1);

    // Frame 2: snapshot must survive grid changes and an ignored second start.
    ga = rand_grid();
    ifa.grid_state = ga;
    base = done_cnt[0];
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    t0 = cyc;
    repeat (100) @(negedge clk);
    ifa.grid_state = '1;
    repeat (200) @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    wait_done(0, 8000, t0, 1 + 411 * 16, "a_snap_latency");
    check_stream(0, 1, 0, 0, 16'hFFE0, 16'h0000, ga, "a_snap");

    // Frame 3: start in the cycle right after done, then reset during PIXELS.
    gb = rand_grid();
    @(negedge clk);
    ifa.grid_state = gb;
    ifa.start = 1'b1;
    chk("a_snap_one_done", done_cnt[0] - base, 1);
    @(negedge clk); ifa.start = 1'b0;
    chk("a_b2b_accept", busy_w[0], 1'b1);
    repeat (1000) @(negedge clk);
    base = done_cnt[0];
    #2 rst_a = 1'b1;
    #1;
    chk("a_rst_cs", cs_w[0], 1'b1);
    chk("a_rst_busy", busy_w[0], 1'b0);
    chk("a_rst_scl", scl_w[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (30) @(negedge clk);
    chk("a_rst_no_done", done_cnt[0] - base, 0);

    // Frame 4: full frame after the aborted one.
    ga = rand_grid();
    ifa.grid_state = ga;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    t0 = cyc;
    wait_done(0, 8000, t0, 1 + 411 * 16, "a_after_rst_latency");
    check_stream(0, 1, 0, 0, 16'hFFE0, 16'h0000, ga, "a_after_rst");

    repeat (5) @(negedge clk);
    chk("a_pin_timing", viol[0], 0);
    chk("b_pin_timing", viol[1], 0);
    chk("c_pin_timing", viol[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_lcd_renderer.md
Name: grid_lcd_renderer

Overview:
- Hardware reader of the 200-bit `grid_state` vector that `tetris_grid` writes. It renders the 10x20 playfield to the SPI LCD without processor involvement.
- On a start pulse it snapshots the grid, then sends column/row address-set commands, a memory-write command and the RGB565 pixel stream. Each cell is drawn as a CELL_PX x CELL_PX block.
- Drives `lcd_sda`, `lcd_scl`, `lcd_cs` and `lcd_rs`; the top level muxes these against the processor SPI path.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal values are 1 and above.
- CELL_PX, 6: pixels per cell edge; legal values are 1 to 8.
- X_OFF, 0: LCD column of the playfield's left edge.
- Y_OFF, 0: LCD row of the playfield's top edge.
- FG_COLOR, 16'hFFE0: RGB565 colour of an occupied cell.
- BG_COLOR, 16'h0000: RGB565 colour of an empty cell.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to render a frame.
- grid_state  input  200  playfield; bit r*10+c is row r (0 = top), column c (0 = left); 1 means occupied.
- busy  output  1  high from the accepted start through the end of the frame.
- done  output  1  one-cycle pulse when the frame completes.
- lcd_sda  output  1  SPI MOSI.
- lcd_scl  output  1  SPI clock, mode 0.
- lcd_cs  output  1  chip select, active low.
- lcd_rs  output  1  0 = command byte, 1 = data byte.

Behaviour:
- Reset: one clock, asynchronous and active-high. While reset is asserted and on release, all outputs take their reset values: busy=0, done=0, lcd_cs=1, lcd_scl=0, lcd_sda=0, lcd_rs=0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced, and the FSM returns to IDLE.
- FSM states:
  - IDLE -> CMD_CASET on start.
  - CMD_CASET -> PAR_CASET: 4 bytes.
  - PAR_CASET -> CMD_RASET.
  - CMD_RASET -> PAR_RASET: 4 bytes.
  - PAR_RASET -> CMD_RAMWR.
  - CMD_RAMWR -> PIXELS.
  - PIXELS -> FINISH -> IDLE.
- Start acceptance:
  - start is accepted only in IDLE. On the accepting edge, grid_state is latched into an internal snapshot and busy rises.
  - lcd_cs falls on the following edge.
  - start while busy is ignored, with no queuing.
  - Changes to grid_state mid-frame have no effect on the frame.
- Command bytes, sent with lcd_rs=0: 0x2A, 0x2B, 0x2C.
- Parameter and pixel bytes are sent with lcd_rs=1. Let W = 10*CELL_PX and H = 20*CELL_PX.
  - CASET parameters: X_OFF[15:8], X_OFF[7:0], (X_OFF+W-1)[15:8], (X_OFF+W-1)[7:0].
  - RASET parameters: the same form using Y_OFF and H.
- Pixel order:
  - Raster order, py from 0 to H-1 (outer loop), px from 0 to W-1 (inner loop).
  - Cell index is (py/CELL_PX)*10 + px/CELL_PX. This is computed with nested sub-pixel, column and row counters; no divider.
  - Colour is FG_COLOR if the snapshot bit is set, else BG_COLOR. The high byte is sent first.
- Byte serialisation:
  - MSB first; 8 bits; each bit lasts 2*CLK_DIV cycles.
  - lcd_sda and lcd_rs change only while lcd_scl is low, at the start of each bit.
  - lcd_scl is low for the first CLK_DIV cycles of a bit and high for the second CLK_DIV cycles.
  - Bytes run back-to-back, so a byte takes exactly 16*CLK_DIV cycles. lcd_cs stays low for the whole frame.
- Frame length: 11 + 2*W*H bytes. With the defaults this is 14411 bytes.
- FINISH, on the cycle after the last bit's high phase:
  - lcd_scl=0, lcd_cs=1, done=1 for 1 cycle, busy=0.
  - A start on the cycle after done is accepted.
- Total frame latency from the accepting start edge to the done pulse: 1 + (11 + 2*W*H)*16*CLK_DIV cycles.

Test Plan:
- Reset check: assert reset at t=0 and hold 3 cycles -> lcd_cs=1, lcd_scl=0, busy=0, done=0. With start=0, the outputs stay static for 1000 cycles.
- Empty grid, CELL_PX=1, CLK_DIV=1:
  - Start with grid_state=0, sampling lcd_sda on lcd_scl rising edges -> 2A 00 00 00 09 2B 00 00 00 13 2C, then 400 bytes of 0x00.
  - lcd_rs=0 only during 2A, 2B and 2C.
  - done occurs exactly 1+411*16 cycles after the accepting start.
- Corner cells, CELL_PX=2, BG=0x0000, FG=0xFFE0:
  - grid_state bit 0 and bit 199 set -> pixel rows 0-1 start with 2 FG pixels (FF E0 FF E0).
  - Pixel rows 38-39 end with 2 FG pixels; all other pixels are 00 00.
- Snapshot and ignore:
  - Change grid_state to all ones 100 cycles after start -> the stream still reflects the original snapshot.
  - A second start pulse mid-frame -> no effect: one done pulse, and the byte count is unchanged.
- Reset mid-frame: assert reset during the PIXELS state -> lcd_cs=1 and busy=0 immediately, asynchronously, with no done pulse. A new start after release produces a full, correct frame from 0x2A.
- SCLK timing with CLK_DIV=4 -> lcd_scl period is 8 cycles at 50% duty. lcd_sda is stable across every rising edge, and there are no extra edges while lcd_cs=1.
